// File: rtl/phase_sequencer_if.sv
// Handshake bundle between the phase sequencer, the four-phase mode FSM and
// the read/write data ports.
//   master : sequencer side (drives strobe, requests, status)
//   slave  : environment side (drives start, mask, phase flags, acks, read data)
// Signals:
//   start, xor_mask            transaction request and write mask
//   idle, read, write, finish  one-hot phase flags from the mode FSM
//   strobe                     one-cycle advance pulse to the mode FSM
//   rd_req/rd_ack/rd_data      read handshake
//   wr_req/wr_ack/wr_data      write handshake
//   busy, done, timeout_err    transaction status

interface phase_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] xor_mask;
    logic              idle;
    logic              read;
    logic              write;
    logic              finish;
    logic              strobe;
    logic              rd_req;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req;
    logic              wr_ack;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              timeout_err;

    modport master (
        input  start, xor_mask, idle, read, write, finish, rd_ack, rd_data, wr_ack,
        output strobe, rd_req, wr_req, wr_data, busy, done, timeout_err
    );

    modport slave (
        output start, xor_mask, idle, read, write, finish, rd_ack, rd_data, wr_ack,
        input  strobe, rd_req, wr_req, wr_data, busy, done, timeout_err
    );
endinterface

// File: rtl/phase_sequencer.sv
// Phase sequencer: steps the external four-phase mode FSM with a one-cycle
// strobe and performs the per-phase work (read a word, write it back XORed
// with a mask, signal completion). Owns the ack and phase-flag timeouts.
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   asynchronous, active-high reset
//   io_bus  phase_sequencer_if.master (start/mask, phase flags, strobe,
//           read and write handshakes, busy/done/timeout_err)
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_WAIT_START | idle, waiting for start while the mode FSM reports idle
// S_ADV_RD     | strobe issued, waiting for the read flag
// S_DO_RD      | rd_req high, waiting for rd_ack or timeout
// S_ADV_WR     | strobe issued, waiting for the write flag
// S_DO_WR      | wr_req high (normal) or single pass-through cycle (abort)
// S_ADV_FIN    | strobe issued, waiting for the finish flag
// S_DO_FIN     | done pulse, strobe back towards idle
// S_ADV_IDLE   | strobe issued, waiting for the idle flag

module phase_sequencer #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input logic                i_clk,
    input logic                i_rst,
    phase_sequencer_if.master  io_bus
);

    typedef enum logic [2:0] {
        S_WAIT_START,
        S_ADV_RD,
        S_DO_RD,
        S_ADV_WR,
        S_DO_WR,
        S_ADV_FIN,
        S_DO_FIN,
        S_ADV_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] L_TMO    = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] L_TMO_M1 = CNT_W'(TIMEOUT_CYC - 1);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                r_strobe, w_strobe_nxt;
    logic                r_abort, w_abort_nxt;
    logic                r_tmo_err, w_tmo_err_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic [DATA_W-1:0]   r_mask, w_mask_nxt;
    logic                w_flag_hit;
    state_t              w_adv_target;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_WAIT_START;
            r_cnt     <= '0;
            r_strobe  <= 1'b0;
            r_abort   <= 1'b0;
            r_tmo_err <= 1'b0;
            r_data    <= '0;
            r_mask    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_strobe  <= w_strobe_nxt;
            r_abort   <= w_abort_nxt;
            r_tmo_err <= w_tmo_err_nxt;
            r_data    <= w_data_nxt;
            r_mask    <= w_mask_nxt;
        end
    end

    // Saturating increment: the counter parks at the timeout value.
    assign w_cnt_inc = (r_cnt == L_TMO) ? r_cnt : r_cnt + CNT_W'(1);

    // Which phase flag each ADV state waits for, and where it leads.
    always_comb begin
        w_flag_hit   = 1'b0;
        w_adv_target = S_WAIT_START;
        case (r_state)
            S_ADV_RD:   begin w_flag_hit = io_bus.read;   w_adv_target = S_DO_RD;      end
            S_ADV_WR:   begin w_flag_hit = io_bus.write;  w_adv_target = S_DO_WR;      end
            S_ADV_FIN:  begin w_flag_hit = io_bus.finish; w_adv_target = S_DO_FIN;     end
            S_ADV_IDLE: begin w_flag_hit = io_bus.idle;   w_adv_target = S_WAIT_START; end
            default:    begin w_flag_hit = 1'b0;          w_adv_target = S_WAIT_START; end
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_strobe_nxt  = 1'b0;
        w_abort_nxt   = r_abort;
        w_tmo_err_nxt = r_tmo_err;
        w_data_nxt    = r_data;
        w_mask_nxt    = r_mask;
        case (r_state)
            S_WAIT_START: begin
                if (io_bus.start && io_bus.idle) begin
                    w_mask_nxt    = io_bus.xor_mask;
                    w_tmo_err_nxt = 1'b0;
                    w_abort_nxt   = 1'b0;
                    w_strobe_nxt  = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_ADV_RD;
                end
            end
            S_ADV_RD, S_ADV_WR, S_ADV_FIN, S_ADV_IDLE: begin
                if (w_flag_hit) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_adv_target;
                end else if (r_cnt == L_TMO) begin
                    // Mode FSM never followed the strobe: give up without done.
                    w_tmo_err_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_WAIT_START;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DO_RD: begin
                if (io_bus.rd_ack) begin
                    w_data_nxt   = io_bus.rd_data;
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_ADV_WR;
                end else if (r_cnt == L_TMO_M1) begin
                    // Last allowed request cycle without ack: skip the write.
                    w_tmo_err_nxt = 1'b1;
                    w_abort_nxt   = 1'b1;
                    w_strobe_nxt  = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_ADV_WR;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DO_WR: begin
                if (r_abort || io_bus.wr_ack) begin
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_ADV_FIN;
                end else if (r_cnt == L_TMO_M1) begin
                    w_tmo_err_nxt = 1'b1;
                    w_strobe_nxt  = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_ADV_FIN;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DO_FIN: begin
                w_strobe_nxt = 1'b1;
                w_cnt_nxt    = '0;
                w_state_nxt  = S_ADV_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_START;
            end
        endcase
    end

    // Handshake and status outputs are decodes of the state register.
    assign io_bus.strobe      = r_strobe;
    assign io_bus.rd_req      = (r_state == S_DO_RD);
    assign io_bus.wr_req      = (r_state == S_DO_WR) && !r_abort;
    assign io_bus.wr_data     = r_data ^ r_mask;
    assign io_bus.done        = (r_state == S_DO_FIN);
    assign io_bus.busy        = (r_state != S_WAIT_START) && (r_state != S_ADV_IDLE);
    assign io_bus.timeout_err = r_tmo_err;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: models the four-phase mode FSM,
// auto-responds to read/write requests with programmable ack delays and
// checks latency, strobe count, data path, timeouts and reset behaviour.

module tb_phase_sequencer;

    localparam int DATA_W = 8;
    localparam int NEVER  = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    phase_sequencer_if #(.DATA_W(DATA_W)) u_if ();

    phase_sequencer #(
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (16),
        .CNT_W       (5)
    ) u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (u_if.master)
    );

    always #5 clk = ~clk;

    // Mode FSM model; kill hides every phase flag to provoke mismatches.
    typedef enum logic [1:0] {M_IDLE, M_READ, M_WRITE, M_FINISH} mode_t;
    mode_t r_mode;
    logic  kill = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mode <= M_IDLE;
        else if (u_if.strobe) r_mode <= mode_t'(r_mode + 2'd1);
    end

    assign u_if.idle   = (r_mode == M_IDLE)   && !kill;
    assign u_if.read   = (r_mode == M_READ)   && !kill;
    assign u_if.write  = (r_mode == M_WRITE)  && !kill;
    assign u_if.finish = (r_mode == M_FINISH) && !kill;

    // Request responder: ack after a programmable number of request cycles.
    int          rd_delay  = 0;
    int          wr_delay  = 0;
    logic [7:0]  rd_val    = 8'h00;
    logic        stray_ack = 1'b0;

    initial begin
        int rd_wait;
        int wr_wait;
        rd_wait = 0;
        wr_wait = 0;
        u_if.rd_ack  = 1'b0;
        u_if.wr_ack  = 1'b0;
        u_if.rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            u_if.rd_data = rd_val;
            if (u_if.rd_req) begin
                u_if.rd_ack = (rd_wait == rd_delay);
                rd_wait++;
            end else begin
                u_if.rd_ack = stray_ack;
                rd_wait = 0;
            end
            if (u_if.wr_req) begin
                u_if.wr_ack = (wr_wait == wr_delay);
                wr_wait++;
            end else begin
                u_if.wr_ack = stray_ack;
                wr_wait = 0;
            end
        end
    end

    // Cycle counter and event monitor.
    int         cyc = 0;
    int         strobe_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, sreq_cnt = 0;
    int         done_cyc = 0, prev_done_cyc = 0;
    logic [7:0] last_wr_data = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.strobe) strobe_cnt++;
            if (u_if.rd_req) rd_cnt++;
            if (u_if.wr_req) begin
                wr_cnt++;
                last_wr_data = u_if.wr_data;
            end
            if (u_if.done) begin
                done_cnt++;
                prev_done_cyc = done_cyc;
                done_cyc = cyc;
            end
            if (u_if.strobe && (u_if.rd_req || u_if.wr_req)) sreq_cnt++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int   lat, d_strobe, d_rd, d_wr, d_done;
    logic busy_at_acc, tmo_at_acc;

    task automatic run_txn(input logic [7:0] mask, input logic [7:0] data,
                           input int rdly, input int wdly);
        int a, b_str, b_rd, b_wr, b_done;
        bit seen;
        tick();
        rd_val = data;
        rd_delay = rdly;
        wr_delay = wdly;
        u_if.xor_mask = mask;
        u_if.start = 1'b1;
        a = cyc + 1;
        b_str = strobe_cnt; b_rd = rd_cnt; b_wr = wr_cnt; b_done = done_cnt;
        tick();
        u_if.start = 1'b0;
        busy_at_acc = u_if.busy;
        tmo_at_acc  = u_if.timeout_err;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done_cnt != b_done) seen = 1'b1;
            else tick();
        end
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
        lat = seen ? (done_cyc - a) : -1;
        repeat (4) tick();
        d_strobe = strobe_cnt - b_str;
        d_rd     = rd_cnt - b_rd;
        d_wr     = wr_cnt - b_wr;
        d_done   = done_cnt - b_done;
    endtask

    initial begin
        int b_str, b_done;
        bit seen;
        u_if.start = 1'b0;
        u_if.xor_mask = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check_eq("rst_strobe", u_if.strobe, 1'b0);
        check_eq("rst_busy", u_if.busy, 1'b0);
        check_eq("rst_done", u_if.done, 1'b0);
        check_eq("rst_tmo", u_if.timeout_err, 1'b0);
        check_eq("rst_reqs", {u_if.rd_req, u_if.wr_req}, 2'b00);
        check_eq("rst_wr_data", u_if.wr_data, 8'h00);

        // Zero-wait transaction: 0xA5 ^ 0x0F = 0xAA.
        run_txn(8'h0F, 8'hA5, 0, 0);
        check_eq("t1_busy_acc", busy_at_acc, 1'b1);
        check_eq("t1_latency", lat, 8);
        check_eq("t1_strobes", d_strobe, 4);
        check_eq("t1_rd_cycles", d_rd, 1);
        check_eq("t1_wr_cycles", d_wr, 1);
        check_eq("t1_wr_data", last_wr_data, 8'hAA);
        check_eq("t1_tmo", u_if.timeout_err, 1'b0);
        check_eq("t1_done_cnt", d_done, 1);
        check_eq("t1_idle_busy", {u_if.idle, u_if.busy}, 2'b10);

        // Read ack five cycles late.
        run_txn(8'hFF, 8'h3C, 5, 0);
        check_eq("t2_latency", lat, 13);
        check_eq("t2_rd_cycles", d_rd, 6);
        check_eq("t2_wr_data", last_wr_data, 8'hC3);
        check_eq("t2_strobes", d_strobe, 4);

        // Read never acked: abort path still reaches done.
        run_txn(8'h00, 8'h77, NEVER, 0);
        check_eq("t3_latency", lat, 23);
        check_eq("t3_rd_cycles", d_rd, 16);
        check_eq("t3_wr_cycles", d_wr, 0);
        check_eq("t3_tmo", u_if.timeout_err, 1'b1);
        check_eq("t3_done_cnt", d_done, 1);
        check_eq("t3_strobes", d_strobe, 4);
        check_eq("t3_idle", u_if.idle, 1'b1);

        // Write never acked; the error from t3 clears on accept.
        run_txn(8'h55, 8'h12, 0, NEVER);
        check_eq("t4_tmo_cleared", tmo_at_acc, 1'b0);
        check_eq("t4_latency", lat, 23);
        check_eq("t4_wr_cycles", d_wr, 16);
        check_eq("t4_wr_data", last_wr_data, 8'h47);
        check_eq("t4_tmo", u_if.timeout_err, 1'b1);

        // Both acks delayed.
        run_txn(8'h80, 8'h01, 2, 3);
        check_eq("t5_latency", lat, 13);
        check_eq("t5_rd_cycles", d_rd, 3);
        check_eq("t5_wr_cycles", d_wr, 4);
        check_eq("t5_wr_data", last_wr_data, 8'h81);
        check_eq("t5_tmo", u_if.timeout_err, 1'b0);

        // Stray acks and start while the idle flag is low.
        tick();
        b_str = strobe_cnt; b_done = done_cnt;
        kill = 1'b1; stray_ack = 1'b1; u_if.start = 1'b1;
        repeat (5) tick();
        u_if.start = 1'b0; kill = 1'b0;
        repeat (3) tick();
        stray_ack = 1'b0;
        tick();
        check_eq("t6_strobes", strobe_cnt - b_str, 0);
        check_eq("t6_busy", u_if.busy, 1'b0);
        check_eq("t6_reqs", {u_if.rd_req, u_if.wr_req}, 2'b00);
        check_eq("t6_done_cnt", done_cnt - b_done, 0);

        // start held high: back-to-back transactions every 12 cycles.
        rd_delay = 0; wr_delay = 0; rd_val = 8'hA5; u_if.xor_mask = 8'h0F;
        b_str = strobe_cnt; b_done = done_cnt;
        u_if.start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (done_cnt - b_done >= 2) seen = 1'b1;
        end
        u_if.start = 1'b0;
        check_eq("t7_two_done", seen, 1'b1);
        check_eq("t7_period", done_cyc - prev_done_cyc, 12);
        repeat (4) tick();
        check_eq("t7_strobes", strobe_cnt - b_str, 8);
        check_eq("t7_busy", u_if.busy, 1'b0);
        check_eq("strobe_during_req", sreq_cnt, 0);

        // Mode FSM ignores the strobe: flag timeout without done.
        tick();
        b_str = strobe_cnt; b_done = done_cnt;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        kill = 1'b1;
        repeat (20) tick();
        check_eq("t8_busy", u_if.busy, 1'b0);
        check_eq("t8_tmo", u_if.timeout_err, 1'b1);
        check_eq("t8_done_cnt", done_cnt - b_done, 0);
        check_eq("t8_strobes", strobe_cnt - b_str, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        kill = 1'b0;
        tick();
        check_eq("t8_rst_tmo", u_if.timeout_err, 1'b0);

        // Asynchronous reset in the middle of a stalled write.
        rd_delay = 0; wr_delay = NEVER;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (u_if.wr_req) seen = 1'b1;
        end
        check_eq("t9_wr_req_seen", seen, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        check_eq("t9_wr_req", u_if.wr_req, 1'b0);
        check_eq("t9_busy", u_if.busy, 1'b0);
        check_eq("t9_strobe", u_if.strobe, 1'b0);
        check_eq("t9_idle", u_if.idle, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        run_txn(8'h0F, 8'hA5, 0, 0);
        check_eq("t9_recover_lat", lat, 8);
        check_eq("t9_recover_data", last_wr_data, 8'hAA);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Drives the single-bit strobe that advances the four-phase mode FSM (IDLE→READ→WRITE→FINISH→IDLE).
- Consumes that FSM's one-hot phase flags and performs the per-phase work:
  - READ phase: fetches a word over a req/ack read interface.
  - WRITE phase: writes the captured word (optionally XORed with a mask) over a req/ack write interface.
  - FINISH phase: signals completion, then returns the FSM to IDLE.
- Also owns handshake timeouts.

Parameters:
DATA_W, 8, width of read/write data words
TIMEOUT_CYC, 16, max cycles to wait for an ack before aborting (≥2)
CNT_W, 5, width of timeout counter (must hold TIMEOUT_CYC)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request one transaction; sampled only while idle flag high and sequencer in WAIT_START
xor_mask  input  DATA_W  applied to captured word before write; sampled with start
idle  input  1  phase flag from mode FSM
read  input  1  phase flag from mode FSM
write  input  1  phase flag from mode FSM
finish  input  1  phase flag from mode FSM
strobe  output  1  one-cycle advance pulse to mode FSM
rd_req  output  1  read request, held until rd_ack
rd_ack  input  1  read acknowledge; rd_data valid same cycle
rd_data  input  DATA_W  read data
wr_req  output  1  write request, held until wr_ack
wr_ack  input  1  write acknowledge
wr_data  output  DATA_W  write data, stable while wr_req high
busy  output  1  high from accepted start until done pulse inclusive
done  output  1  one-cycle completion pulse
timeout_err  output  1  sticky abort flag; cleared on next accepted start

Behaviour:
- Reset (async, any cycle, incl. mid-transaction):
  - all outputs 0; state WAIT_START; counter 0; data register 0.
  - The mode FSM is reset by the same rst, so both return to IDLE together.
- States: WAIT_START, ADV_RD, DO_RD, ADV_WR, DO_WR, ADV_FIN, DO_FIN, ADV_IDLE.
- Strobe timing:
  - strobe is registered and high exactly one cycle per ADV_* entry.
  - After strobe, the sequencer stays in ADV_x until the matching flag is high (expected 1 cycle later), then moves to DO_x.
  - strobe is never reasserted while waiting.
- WAIT_START: start=1 and idle=1 → latch xor_mask, busy=1, clear timeout_err, strobe, go to ADV_RD. start while idle=0 is ignored.
- DO_RD:
  - rd_req=1 from entry; counter increments each cycle.
  - rd_ack=1 → capture rd_data, rd_req=0 next cycle, strobe, go to ADV_WR.
  - counter reaches TIMEOUT_CYC with no ack → rd_req=0, timeout_err=1, strobe, go to ADV_WR in abort mode.
- DO_WR:
  - normal mode: wr_data = captured ^ mask, wr_req=1 until wr_ack, same timeout rule.
  - abort mode: no wr_req; strobe issued on the first DO_WR cycle.
  - Then strobe, go to ADV_FIN.
- DO_FIN: done=1 for one cycle, strobe, go to ADV_IDLE. busy drops the cycle after done.
- ADV_IDLE → WAIT_START when idle=1.
- Counter: clears on each DO_x entry; saturates, never wraps.
- Ack timing:
  - An ack arriving on the same cycle req first rises counts as accepted.
  - Acks outside DO_RD/DO_WR are ignored.
- Flag mismatch: expected flag absent for >TIMEOUT_CYC cycles in ADV_x → set timeout_err, go to WAIT_START, busy=0, no done.
- Latency, zero-wait acks: start to done = 8 cycles.
  - Each phase is 2 cycles (strobe cycle + flag-settle cycle), plus 1 req cycle in each of READ and WRITE.

Test Plan:
- Reset mid-DO_WR with wr_req high → next edge-free cycle: wr_req=0, busy=0, strobe=0; mode FSM in IDLE.
- start with rd_data=0xA5, mask=0x0F, immediate acks → wr_data=0xAA while wr_req high; done pulse at cycle 8; exactly 4 strobes; timeout_err=0.
- rd_ack delayed 5 cycles → rd_req high for exactly 6 cycles; done cycle shifts by 5; data correct.
- rd_ack never arrives, TIMEOUT_CYC=16 → rd_req drops after 16 cycles; timeout_err=1; wr_req never asserted; done still pulses; FSM back to IDLE.
- start held high continuously → back-to-back transactions; start accepted only in WAIT_START with idle=1; no strobe while busy waiting on ack.
- Stray rd_ack/wr_ack pulses in WAIT_START; start while idle=0 → no state change, no strobe.
